// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encodings and frame width.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous bit with a configurable
// reset value.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= RESET_VAL;
      r_q    <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 with a one-byte holding register and valid/ready output.
// Define UART_RX_PARITY_EN to add an even-parity bit before the stop bit.
import uart_pkg::*;

module uart_rx #(
  parameter int CLOCK_DIVIDE = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       srx_pad_i,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam logic [15:0] HALF = 16'(CLOCK_DIVIDE / 2);
  localparam logic [15:0] FULL = 16'(CLOCK_DIVIDE);
  localparam logic [2:0]  LAST = 3'(DATA_BITS - 1);

  uart_state_e r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
`ifdef UART_RX_PARITY_EN
  logic        r_par_err;
`endif

  logic w_rx;
  logic w_exp;

  uart_sync2 #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .i_d  (srx_pad_i),
    .o_q  (w_rx)
  );

  assign w_exp = (r_cnt == 16'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (rx_valid && rx_ready)
        rx_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (!w_rx) begin
            r_state <= START;
            r_cnt   <= HALF;
          end
        end
        START: begin
          if (!w_exp) begin
            r_cnt <= r_cnt - 16'd1;
          end else if (!w_rx) begin
            r_state <= DATA;
            r_cnt   <= FULL;
            r_bit   <= '0;
          end else begin
            r_state <= IDLE;
          end
        end
        DATA: begin
          if (!w_exp) begin
            r_cnt <= r_cnt - 16'd1;
          end else begin
            r_shift <= {w_rx, r_shift[7:1]};
            r_cnt   <= FULL;
            r_bit   <= r_bit + 3'd1;
            if (r_bit == LAST)
`ifdef UART_RX_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (!w_exp) begin
            r_cnt <= r_cnt - 16'd1;
          end else begin
            r_par_err <= (^r_shift) ^ w_rx;
            r_state   <= STOP;
            r_cnt     <= FULL;
          end
        end
`endif
        STOP: begin
          if (!w_exp) begin
            r_cnt <= r_cnt - 16'd1;
          end else if (!w_rx) begin
            frame_err <= 1'b1;
            r_state   <= WAIT_IDLE;
`ifdef UART_RX_PARITY_EN
          end else if (r_par_err) begin
            frame_err <= 1'b1;
            r_state   <= IDLE;
`endif
          end else begin
            r_state <= IDLE;
            // a full, unaccepted register keeps its byte; the new one is lost
            if (rx_valid && !rx_ready) begin
              overrun <= 1'b1;
            end else begin
              rx_data  <= r_shift;
              rx_valid <= 1'b1;
            end
          end
        end
        WAIT_IDLE: begin
          if (w_rx)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at CLOCK_DIVIDE=10.
import uart_pkg::*;

module tb_uart_rx;

  localparam int CD = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       srx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int failures = 0;

  int         n_rise = 0;
  int         n_fe = 0;
  int         n_ov = 0;
  logic [7:0] last_data = 8'h00;
  logic       prev_v = 1'b0;

`ifdef UART_RX_PARITY_EN
  logic par_bad = 1'b0;
`endif

  uart_rx #(.CLOCK_DIVIDE(CD)) dut (
    .clk      (clk),
    .reset    (reset),
    .srx_pad_i(srx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid && !prev_v) begin
      n_rise++;
      last_data = rx_data;
    end
    prev_v = rx_valid;
    if (frame_err) n_fe++;
    if (overrun) n_ov++;
  end

  task automatic send(input logic [7:0] d, input logic stop);
    srx = 1'b0;
    repeat (CD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      srx = d[i];
      repeat (CD) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    srx = (^d) ^ par_bad;
    repeat (CD) @(negedge clk);
`endif
    srx = stop;
    repeat (CD) @(negedge clk);
    srx = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks += 4;
    if (rx_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_data got=%h exp=00", rx_data);
    end
    if (rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%b exp=0", rx_valid);
    end
    if (frame_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_ferr got=%b exp=0", frame_err);
    end
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL reset_ovr got=%b exp=0", overrun);
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic();
    int r0, f0, o0;
    r0 = n_rise; f0 = n_fe; o0 = n_ov;
    rx_ready = 1'b1;
    send(8'h55, 1'b1);
    repeat (3) @(negedge clk);
    checks += 5;
    if (n_rise - r0 !== 1) begin
      failures++;
      $display("FAIL basic_rise got=%0d exp=1", n_rise - r0);
    end
    if (last_data !== 8'h55) begin
      failures++;
      $display("FAIL basic_data got=%h exp=55", last_data);
    end
    if (n_fe - f0 !== 0) begin
      failures++;
      $display("FAIL basic_ferr got=%0d exp=0", n_fe - f0);
    end
    if (n_ov - o0 !== 0) begin
      failures++;
      $display("FAIL basic_ovr got=%0d exp=0", n_ov - o0);
    end
    if (rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_valid_clr got=%b exp=0", rx_valid);
    end
  endtask

  task automatic test_overrun();
    int r0, o0;
    r0 = n_rise; o0 = n_ov;
    rx_ready = 1'b0;
    send(8'hA3, 1'b1);
    repeat (3) @(negedge clk);
    checks += 2;
    if (rx_valid !== 1'b1) begin
      failures++;
      $display("FAIL ovr_first_valid got=%b exp=1", rx_valid);
    end
    if (rx_data !== 8'hA3) begin
      failures++;
      $display("FAIL ovr_first_data got=%h exp=a3", rx_data);
    end
    send(8'h0F, 1'b1);
    repeat (3) @(negedge clk);
    checks += 3;
    if (n_ov - o0 !== 1) begin
      failures++;
      $display("FAIL ovr_pulses got=%0d exp=1", n_ov - o0);
    end
    if (rx_data !== 8'hA3) begin
      failures++;
      $display("FAIL ovr_hold_data got=%h exp=a3", rx_data);
    end
    if (n_rise - r0 !== 1) begin
      failures++;
      $display("FAIL ovr_rises got=%0d exp=1", n_rise - r0);
    end
    rx_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL ovr_accept_clr got=%b exp=0", rx_valid);
    end
  endtask

  task automatic test_glitch();
    int r0, f0;
    r0 = n_rise; f0 = n_fe;
    srx = 1'b0;
    repeat (3) @(negedge clk);
    srx = 1'b1;
    repeat (30) @(negedge clk);
    checks += 3;
    if (n_rise - r0 !== 0) begin
      failures++;
      $display("FAIL glitch_valid got=%0d exp=0", n_rise - r0);
    end
    if (n_fe - f0 !== 0) begin
      failures++;
      $display("FAIL glitch_ferr got=%0d exp=0", n_fe - f0);
    end
    if (dut.r_state !== IDLE) begin
      failures++;
      $display("FAIL glitch_state got=%0d exp=%0d", dut.r_state, IDLE);
    end
  endtask

  task automatic test_frame_err();
    int r0, f0;
    r0 = n_rise; f0 = n_fe;
    rx_ready = 1'b1;
    send(8'hFF, 1'b0);
    srx = 1'b0;
    repeat (30) @(negedge clk);
    srx = 1'b1;
    repeat (20) @(negedge clk);
    checks += 2;
    if (n_fe - f0 !== 1) begin
      failures++;
      $display("FAIL ferr_pulses got=%0d exp=1", n_fe - f0);
    end
    if (n_rise - r0 !== 0) begin
      failures++;
      $display("FAIL ferr_valid got=%0d exp=0", n_rise - r0);
    end
    send(8'h12, 1'b1);
    repeat (3) @(negedge clk);
    checks += 2;
    if (n_rise - r0 !== 1) begin
      failures++;
      $display("FAIL ferr_next_rise got=%0d exp=1", n_rise - r0);
    end
    if (last_data !== 8'h12) begin
      failures++;
      $display("FAIL ferr_next_data got=%h exp=12", last_data);
    end
  endtask

  task automatic test_back_to_back();
    int r0;
    logic [7:0] v;
    r0 = n_rise;
    rx_ready = 1'b1;
    send(8'h5A, 1'b1);
    send(8'hC3, 1'b1);
    repeat (3) @(negedge clk);
    v = last_data;
    checks += 2;
    if (n_rise - r0 !== 2) begin
      failures++;
      $display("FAIL b2b_rises got=%0d exp=2", n_rise - r0);
    end
    if (v !== 8'hC3) begin
      failures++;
      $display("FAIL b2b_data got=%h exp=c3", v);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    int r0;
    d = 8'hC3;
    rx_ready = 1'b0;
    send(8'h81, 1'b1);
    repeat (3) @(negedge clk);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h81) begin
      failures++;
      $display("FAIL rst_pre got=%b/%h exp=1/81", rx_valid, rx_data);
    end
    srx = 1'b0;
    repeat (CD) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      srx = d[i];
      repeat (CD) @(negedge clk);
    end
    srx = d[4];
    repeat (3) @(negedge clk);
    reset = 1'b1;
    srx = 1'b1;
    @(negedge clk);
    checks += 3;
    if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin
      failures++;
      $display("FAIL rst_mid_out got=%b/%h exp=0/00", rx_valid, rx_data);
    end
    if (frame_err !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_pulse got=%b/%b exp=0/0", frame_err, overrun);
    end
    if (dut.r_state !== IDLE) begin
      failures++;
      $display("FAIL rst_mid_state got=%0d exp=%0d", dut.r_state, IDLE);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    r0 = n_rise;
    rx_ready = 1'b1;
    send(8'h3C, 1'b1);
    repeat (3) @(negedge clk);
    checks += 2;
    if (n_rise - r0 !== 1) begin
      failures++;
      $display("FAIL rst_next_rise got=%0d exp=1", n_rise - r0);
    end
    if (last_data !== 8'h3C) begin
      failures++;
      $display("FAIL rst_next_data got=%h exp=3c", last_data);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int r0, f0;
    r0 = n_rise; f0 = n_fe;
    rx_ready = 1'b1;
    par_bad = 1'b0;
    send(8'h07, 1'b1);
    repeat (3) @(negedge clk);
    checks += 2;
    if (n_rise - r0 !== 1 || last_data !== 8'h07) begin
      failures++;
      $display("FAIL par_good got=%0d/%h exp=1/07", n_rise - r0, last_data);
    end
    if (n_fe - f0 !== 0) begin
      failures++;
      $display("FAIL par_good_ferr got=%0d exp=0", n_fe - f0);
    end
    par_bad = 1'b1;
    send(8'h07, 1'b1);
    par_bad = 1'b0;
    repeat (3) @(negedge clk);
    checks += 2;
    if (n_fe - f0 !== 1) begin
      failures++;
      $display("FAIL par_bad_ferr got=%0d exp=1", n_fe - f0);
    end
    if (n_rise - r0 !== 1) begin
      failures++;
      $display("FAIL par_bad_valid got=%0d exp=1", n_rise - r0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLOCK_DIVIDE, default 10, meaning clk cycles per UART bit (legal range 4..65535).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port srx_pad_i  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port rx_data  output  8  received byte, valid while rx_valid=1.
REQ-006 SHALL have port rx_valid  output  1  holding register full.
REQ-007 SHALL have port rx_ready  input  1  consumer accepts byte when rx_valid&rx_ready.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-009 SHALL have port overrun  output  1  one-cycle pulse on byte dropped because holding register full.

Function
REQ-010 SHALL pass srx_pad_i through a 2-flop synchronizer, reset to 1; all decisions use the synchronized value.
REQ-011 SHALL implement states IDLE, START, DATA, STOP, WAIT_IDLE (plus PARITY, see REQ-024).
REQ-012 IDLE: on synchronized line 0, SHALL enter START and load bit counter with CLOCK_DIVIDE/2 (integer division).
REQ-013 START: at counter expiry, line 0 -> DATA with counter reloaded to CLOCK_DIVIDE; line 1 -> IDLE (glitch rejected, no output).
REQ-014 DATA: at each counter expiry SHALL sample one bit into shift register LSB first; after 8th sample -> STOP, counter reloaded to CLOCK_DIVIDE.
REQ-015 STOP: at expiry, line 1 -> deliver byte per REQ-017, return IDLE; line 0 -> pulse frame_err, discard byte, enter WAIT_IDLE.
REQ-016 WAIT_IDLE: SHALL remain until synchronized line is 1 (break handling), then IDLE.
REQ-017 Delivery: rx_data/rx_valid SHALL update on the clock edge following the stop-bit sample cycle; latency start-edge-to-rx_valid = sync delay + CLOCK_DIVIDE/2 + 9*CLOCK_DIVIDE + 1 clocks.
REQ-018 rx_valid SHALL clear on the edge after a cycle with rx_valid&rx_ready, unless a new byte is delivered that same cycle, in which case the new byte loads and rx_valid stays 1.
REQ-019 Delivery while rx_valid=1 and rx_ready=0 SHALL pulse overrun and keep the old byte unchanged.
REQ-020 rx_data SHALL be stable while rx_valid=1 and not accepted.
REQ-021 Bit counter SHALL be 16 bits wide, decrement to 1 and treat 1 as expiry (no wrap).

Reset
REQ-022 reset SHALL force state IDLE, counters 0, shift register 0x00, rx_data 0x00, rx_valid 0, frame_err 0, overrun 0, synchronizer 1, within one clock.
REQ-023 reset asserted mid-frame SHALL abandon the frame with no output pulse; after release, reception resumes on the next falling edge.

Configuration
REQ-024 With macro UART_RX_PARITY_EN defined, SHALL insert PARITY state between DATA and STOP sampling one even-parity bit; mismatch SHALL pulse frame_err and discard the byte (WAIT_IDLE if stop bit also 0, else IDLE).
REQ-025 Without UART_RX_PARITY_EN, frame SHALL be 8N1 and no parity logic SHALL be present.

Structure
REQ-026 State encodings and the constant DATA_BITS=8 SHALL live in shared package uart_pkg, also used by the transmitter.
REQ-027 Synchronizer SHALL be a separate sub-module uart_sync2 (1-bit, reset value parameterized); remaining logic in uart_rx.

Verification (CLOCK_DIVIDE=10)
REQ-028 Send 0x55 8N1, rx_ready=1 -> rx_valid one cycle, rx_data=0x55, no error pulses.
REQ-029 Send 0xA3 then 0x0F with rx_ready=0 -> first held as 0xA3, overrun pulses once, rx_data remains 0xA3; raising rx_ready clears rx_valid next edge.
REQ-030 Low glitch of 3 clocks on idle line -> no rx_valid, no frame_err, state returns IDLE.
REQ-031 Send 0xFF with stop bit 0, then hold line low 30 clocks -> frame_err pulses once, no rx_valid; next 0x12 received correctly after line idles.
REQ-032 Assert reset at bit 4 of 0xC3 -> all outputs 0 next edge; subsequent 0x3C received correctly.
REQ-033 With UART_RX_PARITY_EN: 0x07 with parity 1 -> rx_data=0x07; with parity 0 -> frame_err pulse, no rx_valid.
